// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file with debug port.
//   DATA_W_DEF / NREGS_DEF : default register width and register count
//   addr_width()           : address width derived from a register count
//   dbg_state_e            : debug access state machine encoding
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;

  // Keeps at least one address bit for degenerate register counts.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_ACCESS = 2'd1,
    DBG_DONE   = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/regfile_sb_db_if.sv
// Debug access bus of the register file.
//   db_req   : request, held until db_ack is seen (four-phase handshake)
//   db_we    : 1 = write, 0 = read
//   db_addr  : register index
//   db_wdata : write data
//   db_rdata : registered read data, held until the next read completes
//   db_ack   : completion, high until db_req drops
// master drives the request side, slave is the register file.
interface regfile_sb_db_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) ();

  logic              db_req;
  logic              db_we;
  logic [AW-1:0]     db_addr;
  logic [DATA_W-1:0] db_wdata;
  logic [DATA_W-1:0] db_rdata;
  logic              db_ack;

  modport master (
    output db_req, db_we, db_addr, db_wdata,
    input  db_rdata, db_ack
  );

  modport slave (
    input  db_req, db_we, db_addr, db_wdata,
    output db_rdata, db_ack
  );

endinterface

// File: rtl/regfile_dbg_fsm.sv
// Debug access sequencer for the register file.
//   clk, reset : clock and synchronous active-high reset
//   dbg        : debug bus (slave side), drives db_rdata / db_ack
//   func_hit   : a pipeline write targets cap_addr this cycle
//   rd_val     : bypassed read value of cap_addr
//   cap_addr   : captured debug address
//   wr_en      : commit a debug write of wr_data to cap_addr this cycle
//   wr_data    : captured debug write data
module regfile_dbg_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  regfile_sb_db_if.slave    dbg,
  input  logic              func_hit,
  input  logic [DATA_W-1:0] rd_val,
  output logic [AW-1:0]     cap_addr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

  dbg_state_e        state_q, state_d;
  logic              cap_we_q, cap_we_d;
  logic [AW-1:0]     cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DBG_IDLE;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
    end
  end

  // The ack is registered from DONE && db_req: it rises one cycle after DONE
  // is entered and falls on the same edge that returns the FSM to IDLE, so it
  // is never high outside DONE.
  always_comb begin
    state_d     = state_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      DBG_IDLE: begin
        if (dbg.db_req) begin
          cap_we_d    = dbg.db_we;
          cap_addr_d  = dbg.db_addr;
          cap_wdata_d = dbg.db_wdata;
          state_d     = DBG_ACCESS;
        end
      end
      DBG_ACCESS: begin
        if (!cap_we_q) begin
          rdata_d = rd_val;
          state_d = DBG_DONE;
        end else if (!func_hit) begin
          // A write to the PC index completes without touching storage.
          wr_en   = (cap_addr_q != PC_IDX);
          state_d = DBG_DONE;
        end
      end
      DBG_DONE: begin
        ack_d = dbg.db_req;
        if (!dbg.db_req) state_d = DBG_IDLE;
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  assign cap_addr     = cap_addr_q;
  assign wr_data      = cap_wdata_q;
  assign dbg.db_rdata = rdata_q;
  assign dbg.db_ack   = ack_q;

endmodule

// File: rtl/regfile_sb_db.sv
// Two-read / two-write register file with write-through bypass, an
// issue scoreboard (busy bits) and a debug access port.
//   clk, reset         : clock and synchronous active-high reset
//   ra1/ra2, rd1/rd2   : combinational read ports (index NREGS-1 returns pc)
//   wa0/wd0/we0        : write port 0 (ALU result)
//   wa1/wd1/we1        : write port 1 (load writeback, wins over port 0)
//   pc                 : value returned for index NREGS-1
//   iss_valid/iss_dst  : marks a destination busy
//   busy1/busy2        : scoreboard state of ra1/ra2
//   dbg                : debug bus (slave)
module regfile_sb_db
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [AW-1:0]     wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we0,
  input  logic [AW-1:0]     wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we1,
  input  logic [DATA_W-1:0] pc,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_dst,
  output logic              busy1,
  output logic              busy2,
  regfile_sb_db_if.slave    dbg
);

  localparam int            NSTORE = NREGS - 1;
  localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NSTORE];
  logic [DATA_W-1:0] regs_d [NSTORE];
  logic [NSTORE-1:0] busy_q, busy_d;
  logic [NSTORE-1:0] func_wr;
  logic [NSTORE-1:0] issue_set;

  logic [AW-1:0]     dbg_addr;
  logic              dbg_wr_en;
  logic [DATA_W-1:0] dbg_wr_data;
  logic [DATA_W-1:0] dbg_rd_val;
  logic              dbg_hit;

  // Port 1 bypass is checked before port 0 so a read agrees with what the
  // register will hold after the edge.
  function automatic logic [DATA_W-1:0] read_val(input logic [AW-1:0] ra);
    if (ra == PC_IDX)            read_val = pc;
    else if (we1 && wa1 == ra)   read_val = wd1;
    else if (we0 && wa0 == ra)   read_val = wd0;
    else if (ra < PC_IDX)        read_val = regs_q[ra];
    else                         read_val = '0;
  endfunction

  // A write landing this cycle hides a busy bit that is about to clear.
  function automatic logic busy_of(input logic [AW-1:0] ra);
    busy_of = 1'b0;
    if (ra < PC_IDX) busy_of = busy_q[ra] && !func_wr[ra];
  endfunction

  // Only stored indices can match, so writes and issues to the PC index
  // fall out naturally.
  always_comb begin
    func_wr   = '0;
    issue_set = '0;
    for (int i = 0; i < NSTORE; i++) begin
      func_wr[i]   = (we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i));
      issue_set[i] = iss_valid && iss_dst == AW'(i);
    end
  end

  // The debug write never coincides with a pipeline write to the same
  // register (the FSM stalls instead), so its position in the order is moot.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NSTORE; i++) begin
      if (dbg_wr_en && dbg_addr == AW'(i)) regs_d[i] = dbg_wr_data;
      if (we0 && wa0 == AW'(i))            regs_d[i] = wd0;
      if (we1 && wa1 == AW'(i))            regs_d[i] = wd1;
    end
  end

  // Set has priority over clear so a re-issue in the writeback cycle stays busy.
  always_comb begin
    busy_d = (busy_q & ~func_wr) | issue_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd1        = read_val(ra1);
    rd2        = read_val(ra2);
    busy1      = busy_of(ra1);
    busy2      = busy_of(ra2);
    dbg_rd_val = read_val(dbg_addr);
    dbg_hit    = 1'b0;
    if (dbg_addr < PC_IDX) dbg_hit = func_wr[dbg_addr];
  end

  regfile_dbg_fsm #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_dbg_fsm (
    .clk      (clk),
    .reset    (reset),
    .dbg      (dbg),
    .func_hit (dbg_hit),
    .rd_val   (dbg_rd_val),
    .cap_addr (dbg_addr),
    .wr_en    (dbg_wr_en),
    .wr_data  (dbg_wr_data)
  );

endmodule

// File: tb/tb_regfile_sb_db.sv
// Scoreboard bench for regfile_sb_db: stimulus pushes expectations keyed by
// cycle (and debug read-data expectations keyed by ack), a monitor compares.
module tb_regfile_sb_db;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int A  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [A-1:0]  ra1, ra2, wa0, wa1, iss_dst;
  logic [DW-1:0] rd1, rd2, wd0, wd1, pc;
  logic          we0, we1, iss_valid, busy1, busy2;

  regfile_sb_db_if #(.DATA_W(DW), .AW(A)) dbg_if ();

  regfile_sb_db #(.DATA_W(DW), .NREGS(NR), .AW(A)) dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa0(wa0), .wd0(wd0), .we0(we0),
    .wa1(wa1), .wd1(wd1), .we1(we1),
    .pc(pc), .iss_valid(iss_valid), .iss_dst(iss_dst),
    .busy1(busy1), .busy2(busy2),
    .dbg(dbg_if)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RD1, K_RD2, K_BUSY1, K_BUSY2, K_ACK, K_RDATA} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] dbg_q[$];
  string       dbg_name_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          ack_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_RD1:   return rd1;
      K_RD2:   return rd2;
      K_BUSY1: return {31'b0, busy1};
      K_BUSY2: return {31'b0, busy2};
      K_ACK:   return {31'b0, dbg_if.db_ack};
      default: return dbg_if.db_rdata;
    endcase
  endfunction

  task automatic expectv(input kind_e k, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc = cyc; c.kind = k; c.exp = exp; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expectDbg(input logic [31:0] exp, input string name);
    dbg_q.push_back(exp);
    dbg_name_q.push_back(name);
  endtask

  initial begin : monitor
    chk_t c;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        if (c.cyc < cyc) begin
          checks++; errors++;
          $display("[TB] FAIL %s: stale check for cycle %0d at cycle %0d", c.name, c.cyc, cyc);
        end else begin
          checkOutput(c.name, sample(c.kind), c.exp);
        end
      end
      if (dbg_if.db_ack && !ack_prev) begin
        if (dbg_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_ack: got ack with rdata 0x%08h expected no ack", dbg_if.db_rdata);
        end else begin
          checkOutput(dbg_name_q.pop_front(), dbg_if.db_rdata, dbg_q.pop_front());
        end
      end
      ack_prev = dbg_if.db_ack;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [A-1:0] r1, input logic [A-1:0] r2,
                               input logic w0e, input logic [A-1:0] w0a, input logic [DW-1:0] w0d,
                               input logic w1e, input logic [A-1:0] w1a, input logic [DW-1:0] w1d,
                               input logic iv, input logic [A-1:0] idst);
    nextCycle();
    ra1 = r1; ra2 = r2;
    we0 = w0e; wa0 = w0a; wd0 = w0d;
    we1 = w1e; wa1 = w1a; wd1 = w1d;
    iss_valid = iv; iss_dst = idst;
  endtask

  task automatic waitAck(input int max_cycles);
    int n;
    n = 0;
    while (!dbg_if.db_ack && n < max_cycles) begin
      nextCycle();
      n++;
    end
    checkOutput("ack_wait", {31'b0, dbg_if.db_ack}, 32'd1);
  endtask

  initial begin : stimulus
    reset = 1'b1; pc = 32'h100;
    ra1 = '0; ra2 = '0; we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; iss_valid = 1'b0; iss_dst = '0;
    dbg_if.db_req = 1'b0; dbg_if.db_we = 1'b0; dbg_if.db_addr = '0; dbg_if.db_wdata = '0;

    nextCycle();
    nextCycle();
    reset = 1'b0;

    // Reset state across every index, PC index returns pc.
    for (int i = 0; i < NR; i++) begin
      applyStimulus(4'(i), 4'(NR - 1 - i), 0, 0, 0, 0, 0, 0, 0, 0);
      expectv(K_RD1, (i == NR - 1) ? 32'h100 : 32'h0, $sformatf("reset_rd1_r%0d", i));
      expectv(K_RD2, (i == 0) ? 32'h100 : 32'h0, $sformatf("reset_rd2_r%0d", NR - 1 - i));
      expectv(K_BUSY1, 0, $sformatf("reset_busy1_r%0d", i));
      expectv(K_BUSY2, 0, $sformatf("reset_busy2_r%0d", NR - 1 - i));
    end
    expectv(K_ACK, 0, "reset_ack");
    expectv(K_RDATA, 0, "reset_rdata");

    // Dual write to the same register: port 1 wins, bypass shows it.
    applyStimulus(3, 3, 1, 3, 32'hAA, 1, 3, 32'hBB, 0, 0);
    expectv(K_RD1, 32'hBB, "dual_wr_bypass");
    applyStimulus(3, 4, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'hBB, "dual_wr_stored");
    expectv(K_RD2, 32'h44, "p0_bypass");
    applyStimulus(4, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'h44, "p0_stored");

    // Scoreboard set / clear / simultaneous set+clear.
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 1, 5);
    expectv(K_BUSY1, 0, "busy_before_set");
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 1, "busy_set");
    expectv(K_BUSY2, 0, "busy_other");
    applyStimulus(5, 5, 1, 5, 32'h1, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 0, "busy_clr_same_cycle");
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 0, "busy_cleared");
    applyStimulus(5, 6, 1, 5, 32'h2, 0, 0, 0, 1, 5);
    expectv(K_BUSY1, 0, "busy_set_clr_visible");
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 1, "busy_set_wins");
    applyStimulus(5, 15, 0, 15, 32'hDEAD, 1, 5, 32'h3, 1, 15);
    expectv(K_BUSY1, 0, "busy_clr_p1");
    applyStimulus(5, 15, 1, 15, 32'hDEAD, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 0, "busy_clr_p1_after");
    expectv(K_BUSY2, 0, "busy_pc");
    expectv(K_RD2, 32'h100, "pc_bypass_ignored");
    applyStimulus(5, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_RD2, 32'h100, "pc_write_ignored");
    expectv(K_RD1, 32'h3, "p1_stored_r5");

    // Debug read of r7: ack two edges after the request is sampled.
    applyStimulus(7, 0, 1, 7, 32'h1234, 0, 0, 0, 0, 0);
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dbg_if.db_req = 1'b1; dbg_if.db_we = 1'b0; dbg_if.db_addr = 4'd7;
    expectDbg(32'h1234, "dbg_rd_r7");
    expectv(K_ACK, 0, "dbg_rd_ack_t0");
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "dbg_rd_ack_t1");
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "dbg_rd_ack_t2");
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 1, "dbg_rd_ack_t3");
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 1, "dbg_ack_hold");
    dbg_if.db_req = 1'b0;
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "dbg_ack_release");
    expectv(K_RDATA, 32'h1234, "dbg_rdata_hold");

    // Debug read of the PC index.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dbg_if.db_req = 1'b1; dbg_if.db_we = 1'b0; dbg_if.db_addr = 4'd15;
    expectDbg(32'h100, "dbg_rd_pc");
    waitAck(8);
    dbg_if.db_req = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "dbg_pc_release");

    // Debug write r2 stalled by two pipeline writes to r2.
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dbg_if.db_req = 1'b1; dbg_if.db_we = 1'b1; dbg_if.db_addr = 4'd2; dbg_if.db_wdata = 32'h55;
    expectDbg(32'h100, "dbg_wr_rdata_held");
    applyStimulus(2, 0, 1, 2, 32'h77, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'h77, "stall_bypass");
    expectv(K_ACK, 0, "dbg_wr_ack_s0");
    applyStimulus(2, 0, 1, 2, 32'h78, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'h78, "stall_bypass2");
    expectv(K_ACK, 0, "dbg_wr_ack_s1");
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'h78, "stalled_no_write");
    expectv(K_ACK, 0, "dbg_wr_ack_s2");
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_RD1, 32'h55, "dbg_wr_visible");
    expectv(K_ACK, 0, "dbg_wr_ack_s3");
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 1, "dbg_wr_ack");
    dbg_if.db_req = 1'b0;
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "dbg_wr_release");

    // Reset while the debug write sits in ACCESS, with a write and issue.
    applyStimulus(2, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    dbg_if.db_req = 1'b1; dbg_if.db_we = 1'b1; dbg_if.db_addr = 4'd2; dbg_if.db_wdata = 32'h99;
    applyStimulus(2, 6, 1, 6, 32'h66, 0, 0, 0, 1, 4);
    reset = 1'b1;
    dbg_if.db_req = 1'b0;
    expectv(K_ACK, 0, "abort_ack_access");
    applyStimulus(2, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    expectv(K_RD1, 0, "abort_no_write");
    expectv(K_RD2, 0, "reset_over_write");
    expectv(K_ACK, 0, "abort_ack0");
    applyStimulus(4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_BUSY1, 0, "reset_over_issue");
    expectv(K_ACK, 0, "abort_ack1");
    expectv(K_RDATA, 0, "reset_rdata_clr");
    expectv(K_RD2, 0, "abort_r2_zero");
    applyStimulus(4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    expectv(K_ACK, 0, "abort_ack2");

    nextCycle();
    nextCycle();
    checkOutput("pending_checks", chk_q.size() + dbg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/regfile_sb_db.md
REGFILE_SB_DB -- requirements
Module: regfile_sb_db

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, register width
- NREGS, 16, architectural registers; index NREGS-1 is the PC
- AW, clog2(NREGS), address width
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- ra1/ra2  in  AW  read addresses
- rd1/rd2  out  DATA_W  read data
- wa0, wd0, we0  in  AW/DATA_W/1  write port 0 (ALU result)
- wa1, wd1, we1  in  AW/DATA_W/1  write port 1 (load writeback)
- pc  in  DATA_W  value returned for index NREGS-1
- iss_valid, iss_dst  in  1/AW  issue marks destination busy
- busy1/busy2  out  1  scoreboard state of ra1/ra2
- db_req, db_we, db_addr, db_wdata  in  1/1/AW/DATA_W  debug request
- db_rdata  out  DATA_W  debug read data, registered
- db_ack  out  1  debug completion

Function
REQ-003 Storage SHALL hold NREGS-1 registers of DATA_W bits; index NREGS-1 has no storage.
REQ-004 Reads SHALL be combinational: address NREGS-1 -> pc; else we1&&wa1==ra -> wd1; else we0&&wa0==ra -> wd0; else stored value.
REQ-005 Writes SHALL take effect at posedge; when both ports target the same address, port 1 SHALL win.
REQ-006 Writes to index NREGS-1 SHALL be ignored by storage and scoreboard.
REQ-007 busy[i] SHALL set at posedge when iss_valid && iss_dst==i and clear at posedge on a functional write to i; simultaneous set and clear of the same i SHALL leave it set.
REQ-008 busyN SHALL equal busy[raN] && !(a functional write to raN this cycle); busy for index NREGS-1 SHALL always read 0.
REQ-009 Debug FSM states SHALL be IDLE, ACCESS, DONE.
REQ-010 IDLE: on db_req=1, capture db_we/db_addr/db_wdata, go to ACCESS.
REQ-011 ACCESS, read: load db_rdata with the REQ-004 value for the captured address; go to DONE.
REQ-012 ACCESS, write: if any functional write targets the captured address this cycle, stay in ACCESS (stall); otherwise write db_wdata and go to DONE; debug writes SHALL NOT alter busy bits; a write to NREGS-1 SHALL complete without effect.
REQ-013 DONE: db_ack=1; return to IDLE when db_req=0 (four-phase handshake); db_ack SHALL be 0 in all other states.
REQ-014 Uncontended latency SHALL be db_req sampled at edge t -> db_ack high after edge t+2; debug write visible on read ports after edge t+1.
REQ-015 db_rdata SHALL hold its value until the next debug read completes.

Reset
REQ-016 Reset SHALL zero all storage, clear all busy bits, force FSM to IDLE, db_ack=0, db_rdata=0.
REQ-017 Reset during ACCESS or DONE SHALL abort the transaction with no write and no ack; reset SHALL override simultaneous writes and issues.

Structure
REQ-018 Package regfile_pkg SHALL hold DATA_W/NREGS defaults, the AW derivation and the debug state enumeration.
REQ-019 The debug FSM SHALL be a sub-module regfile_dbg_fsm; storage, bypass and scoreboard stay in regfile_sb_db.

Verification
REQ-020 Reset, then read r0..r14 and r15 with pc=0x100 -> rd=0 for r0..r14, 0x100 for r15, busy1/busy2=0.
REQ-021 we0=1 wa0=3 wd0=0xAA and we1=1 wa1=3 wd1=0xBB, ra1=3 -> rd1=0xBB same cycle; r3=0xBB after edge.
REQ-022 Issue iss_dst=5; next cycle busy1=1 for ra1=5; we0 wa0=5 -> busy1=0 same cycle, busy[5]=0 after edge; issue+write to 5 together -> busy stays 1.
REQ-023 Debug read r7=0x1234: db_req at edge t -> db_ack high after t+2, db_rdata=0x1234; ack held until db_req drops, then IDLE.
REQ-024 Debug write r2=0x55 while we0 wa0=2 for two cycles -> FSM stalls in ACCESS, then r2=0x55, ack follows; reset asserted in ACCESS -> no write, db_ack stays 0.
